// File: rtl/lockin_capture_pkg.sv
// rtl/lockin_capture_pkg.sv - shared types and constants for the lock-in capture streamer
package lockin_capture_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 14;
    localparam int DEF_AVG_W  = 4;

    // Guard bits so a full 2^15-sample block sum cannot overflow the accumulator.
    localparam int ACC_EXT    = 15;
    localparam int ACC_W      = DEF_DATA_W + ACC_EXT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/lockin_skid_fifo2.sv
// rtl/lockin_skid_fifo2.sv - 2-entry valid/ready output buffer with simultaneous push/pop
module lockin_skid_fifo2 #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] src_data,
    output logic         src_valid,
    input  logic         src_ready,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign src_data  = head_q;
    assign src_valid = (cnt_q != 2'd0);
    assign full      = (cnt_q == 2'd2);
    assign empty     = (cnt_q == 2'd0);
    assign pop       = src_valid & src_ready;

    // Head always holds the oldest word so src_data stays stable under stall.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = push_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d = push_data;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        cnt_d  = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/lockin_capture_streamer.sv
// rtl/lockin_capture_streamer.sv - block averager feeding the capture FIFO; option LOCKIN_CAPTURE_ROUND_EN
module lockin_capture_streamer
    import lockin_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int AVG_W  = DEF_AVG_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         capture_len,
    input  logic [AVG_W-1:0]         avg_log2,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_in_valid,
    output logic [DATA_W-1:0]        src_data,
    output logic                     src_valid,
    input  logic                     src_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int ACC_L = DATA_W + ACC_EXT;
    localparam int BLK_W = 2 ** AVG_W;

    state_e                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [AVG_W-1:0]          k_q, k_d;
    logic signed [ACC_L-1:0]   acc_q, acc_d;
    logic [BLK_W-1:0]          blk_q, blk_d;
    logic [LEN_W-1:0]          words_q, words_d;
    logic                      ovf_q, ovf_d;
    logic                      done_q, done_d;

    logic signed [ACC_L-1:0]   sum;
    logic signed [ACC_L-1:0]   rnd;
    logic [DATA_W-1:0]         result;
    logic                      block_last;
    logic                      push_req;
    logic                      push_ok;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      drain_empty_next;

    // Block sum including the current sample, rounded and shifted down to one word.
    always_comb begin
        sum = acc_q + {{ACC_EXT{sample_in[DATA_W-1]}}, sample_in};
`ifdef LOCKIN_CAPTURE_ROUND_EN
        rnd = (k_q == '0) ? '0 : (ACC_L'(1) <<< (k_q - 1'b1));
`else
        rnd = '0;
`endif
        result     = DATA_W'((sum + rnd) >>> k_q);
        block_last = (blk_q == BLK_W'((BLK_W'(1) << k_q) - BLK_W'(1)));
    end

    assign pop     = src_valid & src_ready;
    assign push_ok = push_req & (~fifo_full | pop);
    // Only DRAIN consults this and nothing is pushed there, so just a pop of the last word matters.
    assign drain_empty_next = fifo_empty | (~fifo_full & src_ready);

    // Capture sequencing: arm, accumulate blocks, then drain the buffer.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        k_d      = k_q;
        acc_d    = acc_q;
        blk_d    = blk_q;
        words_d  = words_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        push_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = capture_len;
                    k_d     = avg_log2;
                    acc_d   = '0;
                    blk_d   = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                    state_d = (capture_len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (sample_in_valid) begin
                    if (block_last) begin
                        acc_d    = '0;
                        blk_d    = '0;
                        push_req = 1'b1;
                        if (push_ok) begin
                            words_d = words_q + LEN_W'(1);
                            if ((words_q + LEN_W'(1)) == len_q) begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        acc_d = sum;
                        blk_d = blk_q + BLK_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_empty_next) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            blk_q   <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            blk_q   <= blk_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;

    lockin_skid_fifo2 #(.W(DATA_W)) u_obuf (
        .clock     (clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data (result),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_lockin_capture_streamer.sv
// tb/tb_lockin_capture_streamer.sv - self-checking bench for lockin_capture_streamer
module tb_lockin_capture_streamer;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [13:0]        capture_len = '0;
    logic [3:0]         avg_log2 = '0;
    logic signed [31:0] sample_in = '0;
    logic               sample_in_valid = 1'b0;
    logic [31:0]        src_data;
    logic               src_valid;
    logic               src_ready = 1'b1;
    logic               busy;
    logic               done;
    logic               overflow;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 0;

    // Reference model: capture state, pending words, received words.
    int          m_mode = 0;
    int          m_len = 0;
    int          m_k = 0;
    longint      m_acc = 0;
    int          m_cnt = 0;
    int          m_pushes = 0;
    logic        m_ovf = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] mq[$];
    logic [31:0] got[$];
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;

    lockin_capture_streamer dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .capture_len     (capture_len),
        .avg_log2        (avg_log2),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .src_data        (src_data),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] block_avg(input longint total, input int k);
        longint t;
        t = total;
`ifdef LOCKIN_CAPTURE_ROUND_EN
        if (k > 0) t = t + (longint'(1) <<< (k - 1));
`endif
        t = t >>> k;
        return t[31:0];
    endfunction

    // Compare the DUT against the model before each edge, then advance the model across it.
    always @(negedge clock) begin
        logic [31:0] w;
        bit pop;
        if (mon_en) begin
            chk("valid", src_valid, (mq.size() != 0));
            if (mq.size() != 0) chk("data", src_data, mq[0]);
            chk("done", done, m_done);
            chk("busy", busy, (m_mode != 0));
            chk("overflow", overflow, m_ovf);
            if (prev_stall) begin
                chk("stall_valid", src_valid, 1'b1);
                chk("stall_data", src_data, prev_data);
            end
        end
        prev_stall = (src_valid === 1'b1) && !src_ready && !reset;
        prev_data  = src_data;
        if (reset) begin
            m_mode = 0; m_acc = 0; m_cnt = 0; m_pushes = 0;
            m_ovf = 1'b0; m_done = 1'b0; mq.delete();
        end else begin
            m_done = 1'b0;
            pop = (mq.size() != 0) && src_ready;
            if (pop) begin
                w = mq.pop_front();
                got.push_back(w);
            end
            case (m_mode)
                0: if (start) begin
                    m_len = int'(capture_len); m_k = int'(avg_log2);
                    m_acc = 0; m_cnt = 0; m_pushes = 0; m_ovf = 1'b0;
                    m_mode = (capture_len == 0) ? 2 : 1;
                end
                1: if (sample_in_valid) begin
                    m_acc = m_acc + longint'(sample_in);
                    m_cnt++;
                    if (m_cnt == (1 << m_k)) begin
                        w = block_avg(m_acc, m_k);
                        m_acc = 0; m_cnt = 0;
                        if (mq.size() < 2) begin
                            mq.push_back(w);
                            m_pushes++;
                            if (m_pushes == m_len) m_mode = 2;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                end
                default: if (mq.size() == 0) begin
                    m_done = 1'b1;
                    m_mode = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input int len, input int k);
        start = 1'b1; capture_len = 14'(len); avg_log2 = 4'(k);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] s);
        sample_in = s; sample_in_valid = 1'b1;
        tick();
        sample_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        int len;
        int n;
        tick(); tick();
        reset = 1'b0;
        mon_en = 1;
        chk("rst_valid", src_valid, 1'b0);
        chk("rst_data", src_data, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);

        // Averaging k=2, len=3, samples 1..14 back to back.
        got.delete(); src_ready = 1'b1;
        arm(3, 2);
        for (int i = 1; i <= 14; i++) begin
            sample_in = i; sample_in_valid = 1'b1; tick();
        end
        sample_in_valid = 1'b0;
        wait_idle("avg_idle", 50);
        chk("avg_count", got.size(), 3);
`ifdef LOCKIN_CAPTURE_ROUND_EN
        chk("avg_w0", got[0], 32'd3); chk("avg_w1", got[1], 32'd7); chk("avg_w2", got[2], 32'd11);
`else
        chk("avg_w0", got[0], 32'd2); chk("avg_w1", got[1], 32'd6); chk("avg_w2", got[2], 32'd10);
`endif

        // Negative block and most-negative passthrough.
        got.delete();
        arm(1, 1); send(32'hFFFF_FFFD); send(32'hFFFF_FFFE);
        wait_idle("neg_idle", 20);
`ifdef LOCKIN_CAPTURE_ROUND_EN
        chk("neg_avg", got[0], 32'hFFFF_FFFE);
`else
        chk("neg_avg", got[0], 32'hFFFF_FFFD);
`endif
        got.delete();
        arm(1, 0); send(32'h8000_0000);
        wait_idle("min_idle", 20);
        chk("min_pass", got[0], 32'h8000_0000);

        // Backpressure: 4 words offered while stalled, two are dropped.
        got.delete(); src_ready = 1'b0;
        arm(4, 0);
        for (int i = 1; i <= 10; i++) begin
            sample_in = i; sample_in_valid = (i <= 4); tick();
        end
        sample_in_valid = 1'b0;
        chk("bp_ovf", overflow, 1'b1);
        src_ready = 1'b1;
        send(32'd5); send(32'd6);
        wait_idle("bp_idle", 20);
        chk("bp_count", got.size(), 4);
        chk("bp_w0", got[0], 32'd1); chk("bp_w1", got[1], 32'd2);
        chk("bp_w2", got[2], 32'd5); chk("bp_w3", got[3], 32'd6);

        // Zero-length capture: done two cycles after the start cycle.
        got.delete();
        arm(0, 0);
        chk("len0_done_early", done, 1'b0);
        tick();
        chk("len0_done", done, 1'b1);
        chk("len0_valid", src_valid, 1'b0);
        tick();
        chk("len0_busy", busy, 1'b0);
        chk("len0_words", got.size(), 0);

        // Start while busy is ignored; original length honoured.
        got.delete();
        arm(2, 0);
        tick();
        arm(5, 1);
        send(32'd10); send(32'd11); send(32'd12);
        wait_idle("rearm_idle", 20);
        chk("rearm_count", got.size(), 2);
        chk("rearm_w0", got[0], 32'd10); chk("rearm_w1", got[1], 32'd11);

        // Reset mid-capture, then a clean capture.
        arm(4, 0); send(32'd7); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_valid", src_valid, 1'b0);
        chk("mid_data", src_data, 32'd0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_ovf", overflow, 1'b0);
        got.delete();
        arm(2, 0); send(32'd1); send(32'd2);
        wait_idle("post_idle", 20);
        chk("post_count", got.size(), 2);
        chk("post_w1", got[1], 32'd2);

        // Random stalls and sample gaps.
        for (int r = 0; r < 4; r++) begin
            got.delete();
            len = 1 + int'($urandom_range(0, 5));
            arm(len, int'($urandom_range(0, 2)));
            n = 0;
            while (busy === 1'b1 && n < 2000) begin
                src_ready = 1'($urandom_range(0, 1));
                sample_in_valid = 1'($urandom_range(0, 1));
                sample_in = $urandom;
                tick();
                n++;
            end
            sample_in_valid = 1'b0; src_ready = 1'b1;
            chk("rand_idle", busy, 1'b0);
            tick();
            chk("rand_count", got.size(), len);
        end

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lockin_capture_streamer.md
Name: lockin_capture_streamer

Overview:
- Upstream stage of the 32-bit capture FIFO (8192 words, Avalon-ST sink, Avalon-MM read).
- Takes the lock-in result sample stream and averages blocks of 2^avg_log2 samples.
- Emits exactly capture_len averaged words per armed capture on an Avalon-ST source with ready latency 0.
- Reports busy/done/overflow to the control registers.

Parameters:
DATA_W, 32, sample and output word width (signed)
LEN_W, 14, capture length width; max 8192 words matches the FIFO depth
AVG_W, 4, width of avg_log2; block size 1..2^15 samples

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle arm pulse
capture_len  in  LEN_W  words to emit; latched on start
avg_log2  in  AVG_W  log2 of block size; latched on start
sample_in  in  DATA_W  signed sample from the lock-in chain
sample_in_valid  in  1  sample strobe; no backpressure upstream
src_data  out  DATA_W  Avalon-ST data to the FIFO sink
src_valid  out  1  Avalon-ST valid
src_ready  in  1  Avalon-ST ready; transfer = src_valid & src_ready
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse when the capture completes
overflow  out  1  sticky: an averaged word was dropped; cleared by the next accepted start

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: src_valid=0, src_data=0, busy=0, done=0, overflow=0. State goes to IDLE; accumulator, counters and buffer are cleared.
- Reset mid-capture aborts the capture. No done pulse is generated.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches capture_len and avg_log2, clears overflow, sets busy.
  - Goes to RUN, or to DRAIN if capture_len=0.
  - Samples are ignored in IDLE.
- start while busy: ignored. Latched values are unchanged.
- RUN, accumulation:
  - Each valid sample is added into a DATA_W+15 signed accumulator, and a block counter is incremented.
  - On the 2^k-th sample (k = latched avg_log2), result = (acc + sample_in) >>> k, arithmetic shift, low DATA_W bits kept.
  - The accumulator and block counter restart at 0 on the same cycle.
  - k=0 passes each sample straight through.
- Output buffer:
  - The result is pushed into a 2-entry output buffer and words_pushed is incremented.
  - src_valid rises the cycle after the completing sample (latency 1).
  - If the buffer is full and not popping that cycle, the result is dropped and overflow is set. words_pushed is not incremented.
  - A simultaneous pop and push is legal at full.
- RUN to DRAIN: when words_pushed == capture_len. Further samples are ignored and the partial accumulator is discarded.
- DRAIN:
  - The buffer is emitted in order.
  - When the buffer is empty, done pulses for 1 cycle, busy falls on the same cycle, and the FSM returns to IDLE.
  - capture_len=0: done pulses 1 cycle after DRAIN is entered.
- src_data/src_valid handshake:
  - src_data is held stable while src_valid=1 and src_ready=0.
  - src_valid never drops without a transfer, except on reset.
- Counters do not wrap. capture_len values above 8192 are legal but overflow the downstream FIFO; that is the software's responsibility.

Optional Feature:
- Macro: LOCKIN_CAPTURE_ROUND_EN
- Defined:
  - Adds 2^(k-1) to the sum before the shift (round-half-up), for k>=1.
  - k=0 is unchanged.
- Undefined: truncating arithmetic shift toward -inf.

Decomposition:
- Package lockin_capture_pkg: state enum (IDLE/RUN/DRAIN), DATA_W/LEN_W/AVG_W defaults, accumulator width constant ACC_W = DATA_W+15.
- Sub-module lockin_skid_fifo2: 2-entry valid/ready buffer.
  - Inputs: push, push_data.
  - Outputs: src_* side, full, empty.
  - Supports simultaneous push/pop.

Test Plan:
- Averaging: start, len=3, k=2, src_ready=1; samples 1..12 each cycle -> src_data 2,6,10 (truncated 2.5, 6.5, 10.5). With ROUND_EN -> 3,7,11. Done 1 cycle after the last transfer. Samples 13+ are ignored.
- Negative values: k=1, samples -3,-2 -> -3 (truncate) / -2 (ROUND_EN). k=0, sample 0x80000000 -> 0x80000000 unchanged.
- Backpressure: k=0, len=4, src_ready=0 for 10 cycles while 4 samples arrive -> 2 words buffered. overflow=1. After ready rises, words 1,2 are emitted in order, then capture continues until 4 words are pushed.
- Boundaries: len=0 -> done 2 cycles after start, no src_valid. start while busy -> ignored, original len honoured.
- Reset mid-capture: reset after 1 of 4 words -> all outputs 0 next cycle, no done. A new start runs cleanly.
- Stall stability: src_ready toggled randomly -> src_data stable whenever valid&!ready; transfer count equals len exactly.
